// File: rtl/clock_divider_ctrl.sv
// Single-counter clock divider (/2../16) with valid/ready ratio changes, graceful stop and glitch-free switching.
// Optional tick_count output enabled by defining CLOCK_DIVIDER_CTRL_TICKCNT_EN.
module clock_divider_ctrl #(
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             sel_valid,
    input  logic [SEL_W-1:0] sel_ratio,
    output logic             sel_ready,
    output logic             div_clk,
    output logic             div_tick,
    output logic [SEL_W-1:0] cur_ratio,
    output logic             busy
`ifdef CLOCK_DIVIDER_CTRL_TICKCNT_EN
    ,
    output logic [15:0]      tick_count
`endif
);

    typedef enum logic [1:0] {STOP, RUN, DRAIN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               tick_q, tick_d;
    logic [SEL_W-1:0]   cur_q, cur_d;
    logic [SEL_W-1:0]   pend_q, pend_d;
    logic               chgPend_q, chgPend_d;
    logic               stopPend_q, stopPend_d;
    logic               ready_q, ready_d;

    logic [CNT_W-1:0]   halfLast;
    logic               wrap;
    logic               accept;
    logic               rise;
    logic               stopNow;

    assign halfLast = (CNT_W'(1) << cur_q) - CNT_W'(1);
    assign wrap     = (cnt_q == halfLast);
    assign accept   = sel_valid && ready_q;
    // Every ratio or stop decision is taken only where div_clk would rise.
    assign rise     = (state_q != STOP) && !div_q && wrap;
    assign stopNow  = rise && stopPend_q && !run;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= STOP;
            cnt_q      <= '0;
            div_q      <= 1'b0;
            tick_q     <= 1'b0;
            cur_q      <= '0;
            pend_q     <= '0;
            chgPend_q  <= 1'b0;
            stopPend_q <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            chgPend_q  <= chgPend_d;
            stopPend_q <= stopPend_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        tick_d     = 1'b0;
        cur_d      = cur_q;
        pend_d     = pend_q;
        chgPend_d  = chgPend_q;
        stopPend_d = stopPend_q;
        ready_d    = ready_q;
        if (state_q == STOP) begin
            cnt_d      = '0;
            div_d      = 1'b0;
            stopPend_d = 1'b0;
            if (accept) begin
                cur_d = sel_ratio;
            end
            if (run) begin
                state_d = RUN;
            end
        end else begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            if (wrap && div_q) begin
                div_d = 1'b0;
            end
            if (rise) begin
                if (chgPend_q) begin
                    cur_d     = pend_q;
                    chgPend_d = 1'b0;
                    ready_d   = 1'b1;
                end
                if (stopNow) begin
                    div_d = 1'b0;
                    cnt_d = '0;
                end else begin
                    div_d  = 1'b1;
                    tick_d = 1'b1;
                end
            end
            // A request landing on the stop boundary is applied directly, as it would be in STOP.
            if (accept) begin
                if (stopNow) begin
                    cur_d = sel_ratio;
                end else begin
                    pend_d    = sel_ratio;
                    chgPend_d = 1'b1;
                    ready_d   = 1'b0;
                end
            end
            stopPend_d = !run;
            if (stopNow) begin
                state_d = STOP;
            end else if (chgPend_d || !run) begin
                state_d = DRAIN;
            end else begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        busy      = (state_q != STOP);
        sel_ready = ready_q;
        div_clk   = div_q;
        div_tick  = tick_q;
        cur_ratio = cur_q;
    end

`ifdef CLOCK_DIVIDER_CTRL_TICKCNT_EN
    logic        applied;
    logic [15:0] tickCnt_q;

    assign applied = ((state_q == STOP) && accept) || (rise && chgPend_q) || (stopNow && accept);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tickCnt_q <= '0;
        end else if (applied) begin
            tickCnt_q <= '0;
        end else if (tick_d) begin
            tickCnt_q <= tickCnt_q + 16'd1;
        end
    end

    assign tick_count = tickCnt_q;
`endif

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Self-checking bench for clock_divider_ctrl: directed scenarios plus random run/ratio traffic
// checked against a phase-countdown reference model.
module tb_clock_divider_ctrl;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       run       = 1'b0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_ratio = '0;
    logic       sel_ready;
    logic       div_clk;
    logic       div_tick;
    logic [1:0] cur_ratio;
    logic       busy;
`ifdef CLOCK_DIVIDER_CTRL_TICKCNT_EN
    logic [15:0] tick_count;
`endif

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: level, cycles left in the current phase, applied ratio, queued ratio.
    logic mBusy, mLevel, mTick, mReady, mStopReq;
    int   mCur, mLeft;
    int   pendQ[$];

    logic [5:0] dutVec;
    assign dutVec = {div_clk, div_tick, cur_ratio, sel_ready, busy};

    always #5 clk = ~clk;

    clock_divider_ctrl #(.SEL_W(2), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .sel_valid (sel_valid),
        .sel_ratio (sel_ratio),
        .sel_ready (sel_ready),
        .div_clk   (div_clk),
        .div_tick  (div_tick),
        .cur_ratio (cur_ratio),
        .busy      (busy)
`ifdef CLOCK_DIVIDER_CTRL_TICKCNT_EN
        ,
        .tick_count(tick_count)
`endif
    );

    function automatic void modelReset();
        mBusy = 0; mLevel = 0; mTick = 0; mReady = 1; mStopReq = 0;
        mCur = 0; mLeft = 0;
        pendQ.delete();
    endfunction

    function automatic void modelEdge(input logic r, input logic v, input int ratio);
        logic acc;
        acc   = v && mReady;
        mTick = 0;
        if (!mBusy) begin
            if (v) mCur = ratio;
            if (r) begin
                mBusy = 1; mLevel = 0; mLeft = 1 << mCur;
            end
            mStopReq = 0;
        end else begin
            mLeft--;
            if (mLeft == 0) begin
                if (mLevel) begin
                    mLevel = 0; mLeft = 1 << mCur;
                end else begin
                    if (pendQ.size() > 0) begin
                        mCur = pendQ.pop_front(); mReady = 1;
                    end
                    if (mStopReq && !r) begin
                        mBusy = 0; mLevel = 0;
                        if (acc) begin
                            mCur = ratio; acc = 0;
                        end
                    end else begin
                        mLevel = 1; mTick = 1; mLeft = 1 << mCur;
                    end
                end
            end
            if (acc) begin
                pendQ.push_back(ratio); mReady = 0;
            end
            if (mBusy) mStopReq = !r;
        end
    endfunction

    function automatic logic [5:0] expVec();
        return {mLevel, mTick, 2'(mCur), mReady, mBusy};
    endfunction

    // Drives one clock of stimulus, advances the model on the edge, returns at the next negedge.
    task automatic applyStimulus(input logic r, input logic v, input logic [1:0] ratio);
        run = r; sel_valid = v; sel_ratio = ratio;
        @(posedge clk);
        modelEdge(r, v, int'(ratio));
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 0; run = 0; sel_valid = 0;
        modelReset();
        repeat (2) @(negedge clk);
        nChecks++;
        if (dutVec !== 6'b000010) begin
            nFails++; $display("[TB] FAIL reset_state: got %b want %b", dutVec, 6'b000010);
        end
        reset = 1;
    endtask

    task automatic test_basic_div4();
        int ticks = 0, highs = 0, firstRise = -1;
        applyStimulus(0, 1, 2'd1);
        nChecks++;
        if (cur_ratio !== 2'd1) begin
            nFails++; $display("[TB] FAIL stop_accept: cur_ratio=%0d want 1", cur_ratio);
        end
        applyStimulus(1, 0, 2'd0);
        nChecks++;
        if (busy !== 1'b1) begin
            nFails++; $display("[TB] FAIL busy_on_run: got %b want 1", busy);
        end
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1, 0, 2'd0);
            nChecks++;
            if (dutVec !== expVec()) begin
                nFails++; $display("[TB] FAIL basic cyc %0d: got %b want %b", i, dutVec, expVec());
            end
            if (div_tick) ticks++;
            if (div_clk) highs++;
            if (div_clk && firstRise < 0) firstRise = i;
        end
        nChecks += 3;
        if (firstRise !== 2) begin
            nFails++; $display("[TB] FAIL first_rise: got %0d want 2", firstRise);
        end
        if (ticks !== 4) begin
            nFails++; $display("[TB] FAIL tick_rate: got %0d want 4", ticks);
        end
        if (highs !== 8) begin
            nFails++; $display("[TB] FAIL duty: high cycles %0d want 8", highs);
        end
    endtask

    task automatic test_ratio_change();
        int   guard = 0, stage = 0, lowLen = 0, highLen = 0;
        logic pend = 1, wasReady, sawLow = 0, riseReady = 0;
        logic [1:0] riseCur = 2'd3;
        while (!(mCur == 3 && mLevel && mLeft == 4) && guard < 200) begin
            wasReady = mReady;
            applyStimulus(1, pend, 2'd3);
            if (pend && wasReady) pend = 0;
            guard++;
            nChecks++;
            if (dutVec !== expVec()) begin
                nFails++; $display("[TB] FAIL to_div16 cyc %0d: got %b want %b", guard, dutVec, expVec());
            end
        end
        nChecks++;
        if (guard >= 200) begin
            nFails++; $display("[TB] FAIL to_div16_timeout: waited %0d cycles", guard);
        end
        pend = 1;
        for (int i = 0; i < 60 && stage < 3; i++) begin
            wasReady = mReady;
            applyStimulus(1, pend, 2'd0);
            if (pend && wasReady) pend = 0;
            nChecks++;
            if (dutVec !== expVec()) begin
                nFails++; $display("[TB] FAIL change cyc %0d: got %b want %b", i, dutVec, expVec());
            end
            if (!sel_ready) sawLow = 1;
            case (stage)
                0: if (!div_clk) begin stage = 1; lowLen = 1; end
                1: if (!div_clk) lowLen++;
                   else begin stage = 2; highLen = 1; riseCur = cur_ratio; riseReady = sel_ready; end
                default: if (div_clk) highLen++; else stage = 3;
            endcase
        end
        nChecks += 5;
        if (lowLen !== 8) begin
            nFails++; $display("[TB] FAIL old_low_phase: got %0d want 8", lowLen);
        end
        if (highLen !== 1) begin
            nFails++; $display("[TB] FAIL new_high_phase: got %0d want 1", highLen);
        end
        if (riseCur !== 2'd0) begin
            nFails++; $display("[TB] FAIL cur_at_boundary: got %0d want 0", riseCur);
        end
        if (riseReady !== 1'b1 || sawLow !== 1'b1) begin
            nFails++; $display("[TB] FAIL ready_handshake: afterRise=%b sawLow=%b want 1 1", riseReady, sawLow);
        end
        if (stage !== 3) begin
            nFails++; $display("[TB] FAIL change_timeout: stage %0d want 3", stage);
        end
    endtask

    task automatic test_stop();
        int   guard = 0, stage = 0, lowLen = 0, ticks = 0;
        logic pend = 1, wasReady;
        while (!(mCur == 2 && mLevel && mLeft == 2) && guard < 100) begin
            wasReady = mReady;
            applyStimulus(1, pend, 2'd2);
            if (pend && wasReady) pend = 0;
            guard++;
            nChecks++;
            if (dutVec !== expVec()) begin
                nFails++; $display("[TB] FAIL to_div8 cyc %0d: got %b want %b", guard, dutVec, expVec());
            end
        end
        for (int i = 0; i < 30; i++) begin
            applyStimulus(0, 0, 2'd0);
            nChecks++;
            if (dutVec !== expVec()) begin
                nFails++; $display("[TB] FAIL stop cyc %0d: got %b want %b", i, dutVec, expVec());
            end
            if (div_tick) ticks++;
            if (stage == 0 && !div_clk) stage = 1;
            if (stage == 1 && !div_clk && busy) lowLen++;
        end
        nChecks += 3;
        if (lowLen !== 4) begin
            nFails++; $display("[TB] FAIL stop_low_phase: got %0d want 4", lowLen);
        end
        if (ticks !== 0) begin
            nFails++; $display("[TB] FAIL stop_ticks: got %0d want 0", ticks);
        end
        if (busy !== 1'b0 || div_clk !== 1'b0) begin
            nFails++; $display("[TB] FAIL stop_idle: busy=%b div_clk=%b want 0 0", busy, div_clk);
        end
    endtask

    task automatic test_stop_and_change();
        int guard = 0, t1 = -1, t2 = -1;
        applyStimulus(1, 1, 2'd1);
        while (!mLevel && guard < 20) begin
            applyStimulus(1, 0, 2'd0);
            guard++;
        end
        applyStimulus(0, 1, 2'd3);
        guard = 0;
        while (mBusy && guard < 40) begin
            applyStimulus(0, 0, 2'd0);
            guard++;
            nChecks++;
            if (dutVec !== expVec()) begin
                nFails++; $display("[TB] FAIL stopchg cyc %0d: got %b want %b", guard, dutVec, expVec());
            end
        end
        nChecks++;
        if (cur_ratio !== 2'd3 || busy !== 1'b0) begin
            nFails++; $display("[TB] FAIL stop_with_change: cur=%0d busy=%b want 3 0", cur_ratio, busy);
        end
        applyStimulus(1, 0, 2'd0);
        for (int i = 1; i <= 40; i++) begin
            applyStimulus(1, 0, 2'd0);
            nChecks++;
            if (dutVec !== expVec()) begin
                nFails++; $display("[TB] FAIL div16 cyc %0d: got %b want %b", i, dutVec, expVec());
            end
            if (div_tick && t1 < 0) t1 = i;
            else if (div_tick && t2 < 0) t2 = i;
        end
        nChecks += 2;
        if (t1 !== 8) begin
            nFails++; $display("[TB] FAIL div16_first_rise: got %0d want 8", t1);
        end
        if (t2 - t1 !== 16) begin
            nFails++; $display("[TB] FAIL div16_period: got %0d want 16", t2 - t1);
        end
    endtask

    task automatic test_async_reset();
        int guard = 0, ticks = 0;
        while (!(mCur == 3 && mLevel && mLeft == 4) && guard < 60) begin
            applyStimulus(1, 0, 2'd0);
            guard++;
        end
        nChecks++;
        if (div_clk !== 1'b1 || cur_ratio !== 2'd3) begin
            nFails++; $display("[TB] FAIL pre_reset_high: div_clk=%b cur=%0d want 1 3", div_clk, cur_ratio);
        end
        #2 reset = 0;
        #1;
        nChecks++;
        if (dutVec !== 6'b000010) begin
            nFails++; $display("[TB] FAIL async_reset: got %b want %b", dutVec, 6'b000010);
        end
        modelReset();
        @(negedge clk);
        reset = 1;
        applyStimulus(1, 0, 2'd0);
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1, 0, 2'd0);
            nChecks++;
            if (dutVec !== expVec()) begin
                nFails++; $display("[TB] FAIL post_reset cyc %0d: got %b want %b", i, dutVec, expVec());
            end
            if (div_tick) ticks++;
        end
        nChecks++;
        if (ticks !== 6) begin
            nFails++; $display("[TB] FAIL post_reset_div2: ticks %0d want 6", ticks);
        end
    endtask

    task automatic test_random();
        logic r = 1, pend = 0, wasReady;
        logic [1:0] ratio = 2'd0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) r = !r;
            if (!pend && $urandom_range(0, 9) == 0) begin
                pend  = 1;
                ratio = 2'($urandom_range(0, 3));
            end
            wasReady = mReady;
            applyStimulus(r, pend, ratio);
            if (pend && wasReady) pend = 0;
            nChecks++;
            if (dutVec !== expVec()) begin
                nFails++; $display("[TB] FAIL random cyc %0d: got %b want %b", i, dutVec, expVec());
            end
        end
    endtask

`ifdef CLOCK_DIVIDER_CTRL_TICKCNT_EN
    task automatic test_tick_count();
        int   ticks = 0, guard = 0;
        logic pend = 1, wasReady;
        reset = 0;
        modelReset();
        repeat (2) @(negedge clk);
        reset = 1;
        applyStimulus(0, 1, 2'd0);
        applyStimulus(1, 0, 2'd0);
        while (ticks < 70000 && guard < 150000) begin
            applyStimulus(1, 0, 2'd0);
            if (div_tick) ticks++;
            guard++;
        end
        nChecks++;
        if (tick_count !== 16'd4464) begin
            nFails++; $display("[TB] FAIL tick_wrap: got %0d want 4464", tick_count);
        end
        guard = 0;
        while (mCur != 1 && guard < 40) begin
            wasReady = mReady;
            applyStimulus(1, pend, 2'd1);
            if (pend && wasReady) pend = 0;
            guard++;
        end
        nChecks++;
        if (tick_count !== 16'd0 || cur_ratio !== 2'd1) begin
            nFails++; $display("[TB] FAIL tick_clear: count=%0d cur=%0d want 0 1", tick_count, cur_ratio);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_div4();
        test_ratio_change();
        test_stop();
        test_stop_and_change();
        test_async_reset();
        test_random();
`ifdef CLOCK_DIVIDER_CTRL_TICKCNT_EN
        test_tick_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/clock_divider_ctrl.md
Name: clock_divider_ctrl

Overview:
Sequencer for the ripple divider chain's replacement. It runs a single synchronous counter in the clk domain and produces one selectable divided clock (/2, /4, /8 or /16). It also handles start/stop and ratio changes through a valid/ready handshake, with glitch-free switching. Downstream logic consumes either div_clk or the one-cycle div_tick enable.

Parameters:
SEL_W, 2, width of ratio select. Division = 2^(sel+1), so half-period H = 2^sel clk cycles.
CNT_W, 8, internal half-period counter width. Must satisfy 2^CNT_W >= 2^(2^SEL_W - 1).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
run  in  1  level; 1 = divided clock running, 0 = request graceful stop
sel_valid  in  1  ratio change request; sel_ratio is held stable while sel_valid=1 && sel_ready=0
sel_ratio  in  SEL_W  requested ratio code (0:/2, 1:/4, 2:/8, 3:/16)
sel_ready  out  1  ratio request accepted when sel_valid && sel_ready
div_clk  out  1  registered divided clock, 50% duty
div_tick  out  1  one-clk pulse, high in the same cycle div_clk goes 0->1
cur_ratio  out  SEL_W  ratio currently applied to div_clk
busy  out  1  1 when state != STOP

Behaviour:
- Reset (reset=0, asynchronous): state=STOP, cnt=0, div_clk=0, div_tick=0, cur_ratio=0, pending ratio=0, sel_ready=1, busy=0. Outputs clear immediately, including mid-period. No completion of the current period.
- States:
  - STOP: div_clk held at 0, cnt=0.
  - RUN: free-running divide.
  - DRAIN: a ratio change is pending, or a stop is pending, or both.
- STOP behaviour:
  - sel_valid && sel_ready: cur_ratio <= sel_ratio on the next edge. sel_ready stays 1.
  - run=1 sampled at edge k: state=RUN from edge k.
  - div_clk first goes high at edge k+H (H from cur_ratio); div_tick high in that same cycle.
- RUN behaviour:
  - cnt increments each clk. When cnt==H-1: div_clk toggles and cnt=0.
  - div_tick is high exactly in the cycles after a 0->1 toggle.
- Ratio change in RUN or DRAIN:
  - sel_valid && sel_ready captures pending ratio; sel_ready <= 0; state -> DRAIN.
  - Old ratio continues until the low phase completes, i.e. the edge where div_clk would rise.
  - At that boundary: cur_ratio <= pending, cnt=0, div_clk rises. The high phase uses the new H.
  - sel_ready returns to 1 the cycle after the boundary. State -> RUN, or STOP if a stop is pending.
  - A same-ratio request is handled identically; div_clk is unchanged.
- Stop:
  - run=0 sampled in RUN: state -> DRAIN with stop pending.
  - The current period completes (high phase, then full low phase).
  - At the rise boundary: div_clk stays 0, no div_tick, state -> STOP, busy=0 the next cycle.
- run re-asserted during DRAIN: the stop is cancelled; operation continues as RUN with no phase disturbance.
- Simultaneous sel_valid and run falling: both are honoured. The new cur_ratio is applied at the stop boundary.
- Glitch-freedom: no div_clk high or low phase is shorter than min(H_old, H_new) clk cycles, under any interleaving.
- sel_valid while sel_ready=0 is ignored until ready rises. The requester holds its request.

Optional Feature:
CLOCK_DIVIDER_CTRL_TICKCNT_EN
- Defined: adds output tick_count [15:0]. It increments on each div_tick and wraps 0xFFFF->0. It clears on reset and on every applied ratio change.
- Undefined: the port is absent; no counter logic.

Test Plan:
- Reset, then sel_ratio=1 accepted in STOP, run=1 -> div_clk period 4 clk, duty 2/2. First rise 2 cycles after run is sampled. div_tick once per 4 clk. busy=1.
- RUN at /16, request /2 mid high phase -> sel_ready=0 until the boundary. The old low phase lasts 8 cycles, then the high phase lasts 1 cycle. cur_ratio=0 at the boundary, sel_ready=1 the next cycle. No phase is shorter than 1.
- RUN at /8, drop run mid high phase -> the remaining high phase and a 4-cycle low phase complete. Then div_clk stays 0, no further div_tick, busy=0.
- RUN at /4, drop run and request ratio 3 in the same cycle -> the period completes, STOP is entered, cur_ratio=3. A later run=1 gives period 16.
- Assert reset low mid high phase at /16 -> div_clk=0, cur_ratio=0, sel_ready=1 asynchronously. Release with run=1 -> /2 output.
- With CLOCK_DIVIDER_CTRL_TICKCNT_EN: 70000 ticks at /2 -> tick_count=4464 (wrapped). A ratio change clears it to 0.
